// File: rtl/mvm_pkg.sv
// Shared state encoding and sizing for the matrix-vector MAC feeder.
package mvm_pkg;

    localparam int MVM_M        = 3;
    localparam int MVM_N        = 3;
    localparam int MVM_LOAD_LEN = MVM_M * MVM_N + MVM_N + MVM_M;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT,
        DONE
    } mvm_state_t;

    // Bytes in one job's load stream: the M x N matrix, the N-vector, then the M biases.
    function automatic int mvm_load_len(input int m, input int n);
        return m * n + n + m;
    endfunction

endpackage

// File: rtl/mvm_operand_rf.sv
// Operand store for one job: W (row-major), then V, then B, written in stream order.
module mvm_operand_rf
    import mvm_pkg::*;
#(
    parameter int M   = MVM_M,
    parameter int N   = MVM_N,
    parameter int LEN = M * N + N + M,
    parameter int AW  = $clog2(LEN),
    parameter int RW  = 2,
    parameter int KW  = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_idx,
    input  logic [7:0]    wr_data,
    input  logic [RW-1:0] r,
    input  logic [KW-1:0] k,
    output logic [7:0]    w_data,
    output logic [7:0]    v_data,
    output logic [7:0]    b_data
);

    logic [7:0] mem [LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign w_data = mem[AW'(r) * AW'(N) + AW'(k)];
    assign v_data = mem[AW'(M * N) + AW'(k)];
    assign b_data = mem[AW'(M * N + N) + AW'(r)];

endmodule

// File: rtl/mvm_feeder.sv
// Loads one matrix/vector/bias job from a byte stream, issues row-major triples
// to the MAC, then waits for all per-row results before pulsing done.
//
//   state | meaning
//   LOAD  | accepting operand bytes, s_ready high
//   ISSUE | one a/b/x triple per cycle, M*N cycles, no gaps
//   WAIT  | issue finished, counting outstanding row results
//   DONE  | one-cycle done pulse, then back to LOAD
module mvm_feeder
    import mvm_pkg::*;
#(
    parameter int M = MVM_M,
    parameter int N = MVM_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic signed [7:0] mac_a,
    output logic signed [7:0] mac_b,
    output logic [7:0]        mac_x,
    output logic              mac_valid_in,
    input  logic              mac_valid_out,
    input  logic              mac_overflow,
    output logic              busy,
    output logic              done,
    output logic              ovf_seen
);

    localparam int LOAD_LEN = mvm_load_len(M, N);
    localparam int LW       = $clog2(LOAD_LEN);
    localparam int RW       = (M > 1) ? $clog2(M) : 1;
    localparam int KW       = (N > 1) ? $clog2(N) : 1;
    localparam int CW       = $clog2(M + 1);

    mvm_state_t    state;
    logic [LW-1:0] li;
    logic [RW-1:0] r;
    logic [KW-1:0] k;
    logic [CW-1:0] rc;
    logic          load_we;
    logic          rc_full;
    logic          collecting;
    logic [7:0]    w_rd;
    logic [7:0]    v_rd;
    logic [7:0]    b_rd;

    assign load_we    = (state == LOAD) && s_valid && s_ready;
    assign collecting = (state == ISSUE) || (state == WAIT);
    // The last row result may land in the same cycle that WAIT tests for completion.
    assign rc_full    = (rc == CW'(M)) || (mac_valid_out && (rc == CW'(M - 1)));

    mvm_operand_rf #(
        .M  (M),
        .N  (N),
        .LEN(LOAD_LEN),
        .AW (LW),
        .RW (RW),
        .KW (KW)
    ) u_rf (
        .clk    (clk),
        .we     (load_we),
        .wr_idx (li),
        .wr_data(s_data),
        .r      (r),
        .k      (k),
        .w_data (w_rd),
        .v_data (v_rd),
        .b_data (b_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD;
            li           <= '0;
            r            <= '0;
            k            <= '0;
            rc           <= '0;
            s_ready      <= 1'b1;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_x        <= '0;
            mac_valid_in <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ovf_seen     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_we) begin
                        if (li == LW'(LOAD_LEN - 1)) begin
                            li       <= '0;
                            state    <= ISSUE;
                            s_ready  <= 1'b0;
                            ovf_seen <= 1'b0;
                        end else begin
                            li <= li + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    mac_a        <= w_rd;
                    mac_b        <= v_rd;
                    mac_x        <= b_rd;
                    mac_valid_in <= 1'b1;
                    busy         <= 1'b1;
                    if (k == KW'(N - 1)) begin
                        k <= '0;
                        if (r == RW'(M - 1)) begin
                            r     <= '0;
                            state <= WAIT;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                WAIT: begin
                    mac_valid_in <= 1'b0;
                    if (rc_full) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    s_ready <= 1'b1;
                    rc      <= '0;
                    state   <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase

            if (collecting) begin
                if (mac_valid_out && (rc != CW'(M))) begin
                    rc <= rc + 1'b1;
                end
                if (mac_overflow) begin
                    ovf_seen <= 1'b1;
                end
            end
        end
    end

endmodule
